// File: rtl/led_event_blinker.sv
// Turns single-cycle event strobes into LED blinks (ON_CYCLES lit, OFF_CYCLES dark).
// Events that arrive during a blink are queued in a saturating counter and replayed in order.
module led_event_blinker #(
  parameter int ON_CYCLES    = 5000000,
  parameter int OFF_CYCLES   = 5000000,
  parameter int COUNTERWIDTH = 32,
  parameter int PENDWIDTH    = 4
) (
  input  logic                 sys_clk,
  input  logic                 rst_n,
  input  logic                 pulse_in,
  input  logic                 clr,
  output logic                 led_out,
  output logic                 busy,
  output logic [PENDWIDTH-1:0] pending,
  output logic                 overflow
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ON   = 2'd1,
    S_OFF  = 2'd2
  } state_e;

  localparam logic [COUNTERWIDTH-1:0] ON_LAST  = COUNTERWIDTH'(ON_CYCLES - 1);
  localparam logic [COUNTERWIDTH-1:0] OFF_LAST = COUNTERWIDTH'(OFF_CYCLES - 1);
  localparam logic [PENDWIDTH-1:0]    PMAX     = '1;

  state_e                  state_q, state_d;
  logic [COUNTERWIDTH-1:0] timer_q, timer_d;
  logic [PENDWIDTH-1:0]    pend_q, pend_d;
  logic                    led_q, led_d;
  logic                    busy_q, busy_d;
  logic                    ovf_q, ovf_d;
  logic                    start;

  // State register
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
      state_q <= S_IDLE;
      timer_q <= '0;
      pend_q  <= '0;
      led_q   <= 1'b0;
      busy_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      pend_q  <= pend_d;
      led_q   <= led_d;
      busy_q  <= busy_d;
      ovf_q   <= ovf_d;
    end
  end

  // Next-state: phase sequencing, timer and pending queue
  always_comb begin
    // NOTE: every comb output gets a default first so no path can infer a latch.
    state_d = state_q;
    timer_d = timer_q;
    pend_d  = pend_q;
    start   = ((state_q == S_IDLE) || ((state_q == S_OFF) && (timer_q == OFF_LAST)))
              && ((pend_q != '0) || pulse_in);

    unique case (state_q)
      S_ON: begin
        if (timer_q == ON_LAST) begin
          state_d = S_OFF;
          timer_d = '0;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_OFF: begin
        if (timer_q == OFF_LAST) begin
          state_d = start ? S_ON : S_IDLE;
          timer_d = '0;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      default: begin
        state_d = start ? S_ON : S_IDLE;
        timer_d = '0;
      end
    endcase

    // A start with an empty queue consumes pulse_in directly; a start with a
    // non-empty queue pops one and pushes the new pulse, so the count holds.
    if (start) begin
      if (!pulse_in) pend_d = pend_q - 1'b1;
    end else if (pulse_in && (pend_q != PMAX)) begin
      pend_d = pend_q + 1'b1;
    end

    if (clr) begin
      state_d = S_IDLE;
      timer_d = '0;
      pend_d  = '0;
    end
  end

  // Outputs are derived from the next state so they are registered yet aligned with it
  always_comb begin
    led_d  = (state_d == S_ON);
    busy_d = (state_d != S_IDLE);
    ovf_d  = pulse_in && (pend_q == PMAX) && !start && !clr;
  end

  assign led_out  = led_q;
  assign busy     = busy_q;
  assign pending  = pend_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_led_event_blinker.sv
// Self-checking bench for led_event_blinker: directed scenarios with literal expectations
// plus randomized traffic compared every cycle against a position-in-blink reference model.
module tb_led_event_blinker;

  localparam int ON  = 4;
  localparam int OFF = 3;
  localparam int PW  = 2;
  localparam int PMAX = (1 << PW) - 1;
  localparam int PERIOD = ON + OFF;

  logic          sys_clk = 1'b0;
  logic          rst_n   = 1'b0;
  logic          pulse_in = 1'b0;
  logic          clr      = 1'b0;
  logic          led_out, busy, overflow;
  logic [PW-1:0] pending;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  led_event_blinker #(
    .ON_CYCLES   (ON),
    .OFF_CYCLES  (OFF),
    .COUNTERWIDTH(8),
    .PENDWIDTH   (PW)
  ) dut (
    .sys_clk (sys_clk),
    .rst_n   (rst_n),
    .pulse_in(pulse_in),
    .clr     (clr),
    .led_out (led_out),
    .busy    (busy),
    .pending (pending),
    .overflow(overflow)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: position inside the current blink period (-1 = idle),
  // number of queued events, and whether an event was just dropped.
  int m_pos  = -1;
  int m_pend = 0;
  bit m_ovf  = 1'b0;

  always @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pos  <= -1;
      m_pend <= 0;
      m_ovf  <= 1'b0;
    end else begin
      automatic int pos  = m_pos;
      automatic int pend = m_pend;
      automatic bit ovf  = 1'b0;
      automatic bit free = (m_pos == -1) || (m_pos == PERIOD - 1);
      if (clr) begin
        pos  = -1;
        pend = 0;
      end else if (free && (m_pend > 0 || pulse_in)) begin
        pos = 0;
        if (!pulse_in) pend = m_pend - 1;
      end else begin
        pos = free ? -1 : m_pos + 1;
        if (pulse_in) begin
          if (m_pend == PMAX) ovf = 1'b1;
          else pend = m_pend + 1;
        end
      end
      m_pos  <= pos;
      m_pend <= pend;
      m_ovf  <= ovf;
    end
  end

  always @(negedge sys_clk) begin
    if (cmp_en) begin
      check("model led_out",  int'(led_out),  int'(m_pos >= 0 && m_pos < ON));
      check("model busy",     int'(busy),     int'(m_pos >= 0));
      check("model pending",  int'(pending),  m_pend);
      check("model overflow", int'(overflow), int'(m_ovf));
    end
  end

  // Drive inputs on the falling edge, return 1 time unit after the rising edge that samples them.
  task automatic cycle(input logic p, input logic c);
    @(negedge sys_clk);
    pulse_in = p;
    clr      = c;
    @(posedge sys_clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0);
  endtask

  int busy_cnt, blink_cnt, ovf_cnt, led_cnt;
  logic prev_led;

  // Run n quiet cycles while counting busy cycles, LED rising edges and overflow strobes.
  task automatic observe(input int n);
    for (int i = 0; i < n; i++) begin
      cycle(1'b0, 1'b0);
      busy_cnt += int'(busy);
      led_cnt  += int'(led_out);
      ovf_cnt  += int'(overflow);
      if (led_out && !prev_led) blink_cnt++;
      prev_led = led_out;
    end
  endtask

  task automatic clear_counts();
    busy_cnt = 0; blink_cnt = 0; ovf_cnt = 0; led_cnt = 0; prev_led = 1'b0;
  endtask

  initial begin
    int density;
    repeat (3) @(posedge sys_clk);
    @(negedge sys_clk);
    rst_n = 1'b1;
    idle(2);
    cmp_en = 1'b1;
    check("idle led_out", int'(led_out), 0);
    check("idle busy", int'(busy), 0);

    // Single pulse from IDLE: 4 lit, 3 dark, 7 busy, no queueing
    cycle(1'b1, 1'b0);
    check("single first led", int'(led_out), 1);
    check("single pending", int'(pending), 0);
    clear_counts();
    busy_cnt = 1; led_cnt = 1; blink_cnt = 1; prev_led = 1'b1;
    observe(12);
    check("single led cycles", led_cnt, ON);
    check("single busy cycles", busy_cnt, PERIOD);
    check("single blinks", blink_cnt, 1);

    // Four back-to-back pulses: queue steps 1,2,3 then drains with no idle gaps
    clear_counts();
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, 1'b0);
      check("burst4 pending", int'(pending), i);
      busy_cnt += int'(busy);
      ovf_cnt  += int'(overflow);
      if (led_out && !prev_led) blink_cnt++;
      prev_led = led_out;
    end
    observe(35);
    check("burst4 busy cycles", busy_cnt, 4 * PERIOD);
    check("burst4 blinks", blink_cnt, 4);
    check("burst4 overflow", ovf_cnt, 0);
    check("burst4 pending end", int'(pending), 0);

    // Five pulses: the fifth overflows
    clear_counts();
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, 1'b0);
      ovf_cnt += int'(overflow);
      if (led_out && !prev_led) blink_cnt++;
      prev_led = led_out;
    end
    check("burst5 overflow strobe", int'(overflow), 1);
    check("burst5 pending", int'(pending), PMAX);
    observe(40);
    check("burst5 overflow count", ovf_cnt, 1);
    check("burst5 blinks", blink_cnt, 4);

    // Pulse on the last OFF cycle restarts the LED with no idle cycle
    clear_counts();
    cycle(1'b1, 1'b0);
    busy_cnt = 1;
    for (int i = 0; i < ON + OFF - 1; i++) begin
      cycle(1'b0, 1'b0);
      busy_cnt += int'(busy);
    end
    check("back-to-back busy held", busy_cnt, PERIOD);
    check("back-to-back led dark", int'(led_out), 0);
    cycle(1'b1, 1'b0);
    check("back-to-back led restart", int'(led_out), 1);
    check("back-to-back busy", int'(busy), 1);
    check("back-to-back pending", int'(pending), 0);
    idle(12);
    check("back-to-back idle after", int'(busy), 0);

    // Queue two during ON, then clr together with a pulse flushes everything
    cycle(1'b1, 1'b0);
    cycle(1'b1, 1'b0);
    cycle(1'b1, 1'b0);
    check("clr queued", int'(pending), 2);
    cycle(1'b1, 1'b1);
    check("clr led_out", int'(led_out), 0);
    check("clr busy", int'(busy), 0);
    check("clr pending", int'(pending), 0);
    check("clr overflow", int'(overflow), 0);
    clear_counts();
    observe(15);
    check("clr no blinks", blink_cnt, 0);

    // Asynchronous reset mid-ON
    cycle(1'b1, 1'b0);
    cycle(1'b1, 1'b0);
    cycle(1'b0, 1'b0);
    check("pre-reset led", int'(led_out), 1);
    #1;
    rst_n = 1'b0;
    #1;
    check("async reset led_out", int'(led_out), 0);
    check("async reset busy", int'(busy), 0);
    check("async reset pending", int'(pending), 0);
    check("async reset overflow", int'(overflow), 0);
    @(negedge sys_clk);
    #1;
    rst_n = 1'b1;
    cycle(1'b0, 1'b0);
    check("post-reset led_out", int'(led_out), 0);
    check("post-reset busy", int'(busy), 0);
    check("post-reset pending", int'(pending), 0);

    // Randomized traffic with varying density and rare clr
    density = 30;
    for (int i = 0; i < 3000; i++) begin
      if (i % 200 == 0) density = $urandom_range(2, 80);
      cycle(logic'($urandom_range(0, 99) < density), logic'($urandom_range(0, 99) == 0));
    end
    idle(40);
    check("final busy", int'(busy), 0);
    check("final pending", int'(pending), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
